// File: rtl/nco_phase_accumulator.sv
// Phase-continuous NCO core for the lock-in reference channels.
// A phase accumulator advances by (freq_active << FREQ_SHIFT) each enabled
// cycle. A new frequency word is adopted only when the accumulator wraps, so
// the reference never jumps mid-period.
//
// Ports:
//   clk, reset_n  - system clock, asynchronous active-low reset
//   freq_word     - requested frequency word (from the control PIO)
//   enable        - accumulator advances while high
//   sync_clear    - synchronous phase restart, loads freq_word immediately
//   phase_i/q     - in-phase / quadrature (+90 deg) phase words
//   ref_i/q       - square references (MSB of the phase words)
//   wrap_pulse    - one-cycle pulse while acc holds a post-overflow value
//   freq_active   - frequency word currently driving the increment
//   freq_pending  - requested word differs from the active word
//   cycle_count   - completed periods, modulo 2^16
module nco_phase_accumulator #(
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned FREQ_W     = 20,
    parameter int unsigned FREQ_SHIFT = 12,
    parameter int unsigned OUT_W      = 12,
    parameter int unsigned RESET_FREQ = 1310
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [FREQ_W-1:0] freq_word,
    input  logic              enable,
    input  logic              sync_clear,
    output logic [OUT_W-1:0]  phase_i,
    output logic [OUT_W-1:0]  phase_q,
    output logic              ref_i,
    output logic              ref_q,
    output logic              wrap_pulse,
    output logic [FREQ_W-1:0] freq_active,
    output logic              freq_pending,
    output logic [15:0]       cycle_count
);

    localparam int unsigned CNT_W = 16;

    // Quarter-turn offset: 2^(OUT_W-2)
    localparam logic [OUT_W-1:0] QUAD_OFFSET = {2'b01, {(OUT_W-2){1'b0}}};

    logic [ACC_W-1:0]  acc_q,         acc_d;
    logic [FREQ_W-1:0] freq_active_q, freq_active_d;
    logic              freq_pending_q, freq_pending_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic              wrap_pulse_q,  wrap_pulse_d;

    logic [ACC_W-1:0]  inc_c;
    logic [ACC_W:0]    sum_c;
    logic              carry_c;

    // Phase increment and accumulator sum with carry-out as the wrap flag
    always_comb begin
        inc_c   = ACC_W'(freq_active_q) << FREQ_SHIFT;
        sum_c   = {1'b0, acc_q} + {1'b0, inc_c};
        carry_c = sum_c[ACC_W];
    end

    // Next-state: clear beats advance; frequency swaps only on wrap or zero escape
    always_comb begin
        acc_d         = acc_q;
        freq_active_d = freq_active_q;
        cycle_count_d = cycle_count_q;
        wrap_pulse_d  = 1'b0;

        if (sync_clear) begin
            acc_d         = '0;
            freq_active_d = freq_word;
            cycle_count_d = '0;
        end else begin
            if (enable) begin
                acc_d        = sum_c[ACC_W-1:0];
                wrap_pulse_d = carry_c;
                if (carry_c) begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                    freq_active_d = freq_word;
                end
            end
            // A zero increment never wraps, so load a nonzero request directly
            if ((freq_active_q == '0) && (freq_word != '0)) begin
                freq_active_d = freq_word;
            end
        end

        // Compared against the post-edge active word so a load clears it at once
        freq_pending_d = (freq_word != freq_active_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q          <= '0;
            freq_active_q  <= FREQ_W'(RESET_FREQ);
            freq_pending_q <= 1'b0;
            cycle_count_q  <= '0;
            wrap_pulse_q   <= 1'b0;
        end else begin
            acc_q          <= acc_d;
            freq_active_q  <= freq_active_d;
            freq_pending_q <= freq_pending_d;
            cycle_count_q  <= cycle_count_d;
            wrap_pulse_q   <= wrap_pulse_d;
        end
    end

    // Phase words are taps of the accumulator register, no extra pipeline
    always_comb begin
        phase_i = acc_q[ACC_W-1 -: OUT_W];
        phase_q = phase_i + QUAD_OFFSET;
        ref_i   = phase_i[OUT_W-1];
        ref_q   = phase_q[OUT_W-1];
    end

    assign wrap_pulse   = wrap_pulse_q;
    assign freq_active  = freq_active_q;
    assign freq_pending = freq_pending_q;
    assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_nco_phase_accumulator.sv
module tb_nco_phase_accumulator;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  freq_word;
    logic        enable;
    logic        sync_clear;
    logic [3:0]  phase_i;
    logic [3:0]  phase_q;
    logic        ref_i;
    logic        ref_q;
    logic        wrap_pulse;
    logic [7:0]  freq_active;
    logic        freq_pending;
    logic [15:0] cycle_count;

    int checks = 0;
    int errors = 0;

    nco_phase_accumulator #(
        .ACC_W(8), .FREQ_W(8), .FREQ_SHIFT(0), .OUT_W(4), .RESET_FREQ(16)
    ) dut (
        .clk(clk), .reset_n(reset_n), .freq_word(freq_word),
        .enable(enable), .sync_clear(sync_clear),
        .phase_i(phase_i), .phase_q(phase_q), .ref_i(ref_i), .ref_q(ref_q),
        .wrap_pulse(wrap_pulse), .freq_active(freq_active),
        .freq_pending(freq_pending), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        clr;
        logic [7:0]  fw;
        logic [3:0]  pi;
        logic        wr;
        logic [7:0]  fa;
        logic        pd;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [32];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected quadrature and references derive from the expected in-phase word
    task automatic chk(input string tag, input logic [3:0] e_pi, input logic e_wr,
                       input logic [7:0] e_fa, input logic e_pd, input logic [15:0] e_cnt);
        logic [3:0] e_pq;
        e_pq = e_pi + 4'd4;
        cmp({tag, ".phase_i"},      32'(phase_i),      32'(e_pi));
        cmp({tag, ".phase_q"},      32'(phase_q),      32'(e_pq));
        cmp({tag, ".ref_i"},        32'(ref_i),        32'(e_pi[3]));
        cmp({tag, ".ref_q"},        32'(ref_q),        32'(e_pq[3]));
        cmp({tag, ".wrap_pulse"},   32'(wrap_pulse),   32'(e_wr));
        cmp({tag, ".freq_active"},  32'(freq_active),  32'(e_fa));
        cmp({tag, ".freq_pending"}, 32'(freq_pending), 32'(e_pd));
        cmp({tag, ".cycle_count"},  32'(cycle_count),  32'(e_cnt));
    endtask

    task automatic tick(input logic en, input logic clr, input logic [7:0] fw);
        enable     = en;
        sync_clear = clr;
        freq_word  = fw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Tests 1-2: freq 16 for one period (request 32 from edge 6), then 32
        for (int i = 1; i <= 32; i++) begin
            vecs[i-1].en  = 1'b1;
            vecs[i-1].clr = 1'b0;
            vecs[i-1].fw  = (i >= 6) ? 8'd32 : 8'd16;
            if (i <= 16) begin
                vecs[i-1].pi  = 4'(i % 16);
                vecs[i-1].wr  = (i == 16);
                vecs[i-1].fa  = (i < 16) ? 8'd16 : 8'd32;
                vecs[i-1].pd  = (i >= 6) && (i < 16);
                vecs[i-1].cnt = (i == 16) ? 16'd1 : 16'd0;
            end else begin
                vecs[i-1].pi  = 4'((2 * (i - 16)) % 16);
                vecs[i-1].wr  = ((i - 16) % 8) == 0;
                vecs[i-1].fa  = 8'd32;
                vecs[i-1].pd  = 1'b0;
                vecs[i-1].cnt = 16'(1 + (i - 16) / 8);
            end
        end

        reset_n    = 1'b0;
        enable     = 1'b0;
        sync_clear = 1'b0;
        freq_word  = 8'd16;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 4'd0, 1'b0, 8'd16, 1'b0, 16'd0);

        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < 32; k++) begin
            tick(vecs[k].en, vecs[k].clr, vecs[k].fw);
            chk($sformatf("vec%0d", k + 1), vecs[k].pi, vecs[k].wr, vecs[k].fa, vecs[k].pd, vecs[k].cnt);
        end

        // Test 3: zero word sampled on the wrap edge freezes the accumulator
        for (int i = 33; i <= 39; i++) begin
            tick(1'b1, 1'b0, 8'd32);
            chk($sformatf("pre_zero%0d", i), 4'(2 * (i - 32)), 1'b0, 8'd32, 1'b0, 16'd3);
        end
        tick(1'b1, 1'b0, 8'd0);
        chk("zero_load", 4'd0, 1'b1, 8'd0, 1'b0, 16'd4);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 8'd0);
            chk($sformatf("frozen%0d", i), 4'd0, 1'b0, 8'd0, 1'b0, 16'd4);
        end
        tick(1'b0, 1'b0, 8'd48);
        chk("zero_escape", 4'd0, 1'b0, 8'd48, 1'b0, 16'd4);
        tick(1'b1, 1'b0, 8'd48);
        chk("run48_a", 4'd3, 1'b0, 8'd48, 1'b0, 16'd4);
        tick(1'b1, 1'b0, 8'd48);
        chk("run48_b", 4'd6, 1'b0, 8'd48, 1'b0, 16'd4);
        tick(1'b1, 1'b0, 8'd48);
        tick(1'b1, 1'b0, 8'd48);
        tick(1'b1, 1'b0, 8'd48);
        chk("run48_e", 4'd15, 1'b0, 8'd48, 1'b0, 16'd4);

        // Test 4: clear on the edge where 240+48 would carry
        tick(1'b1, 1'b1, 8'd64);
        chk("clear_vs_carry", 4'd0, 1'b0, 8'd64, 1'b0, 16'd0);

        // Test 5: hold mid-period, resume; a withdrawn request clears without load
        tick(1'b1, 1'b0, 8'd64);
        chk("pre_hold", 4'd4, 1'b0, 8'd64, 1'b0, 16'd0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, 8'd64);
            chk($sformatf("hold%0d", i), 4'd4, 1'b0, 8'd64, 1'b0, 16'd0);
        end
        tick(1'b1, 1'b0, 8'd80);
        chk("resume_req", 4'd8, 1'b0, 8'd64, 1'b1, 16'd0);
        tick(1'b1, 1'b0, 8'd64);
        chk("req_withdrawn", 4'd12, 1'b0, 8'd64, 1'b0, 16'd0);
        tick(1'b1, 1'b0, 8'd64);
        chk("resume_wrap", 4'd0, 1'b1, 8'd64, 1'b0, 16'd1);

        // Test 6: inc 255 carries on every edge except the one leaving acc=0,
        // so after n edges the wrap count is n - ceil(n/256)
        tick(1'b1, 1'b1, 8'd255);
        chk("clear255", 4'd0, 1'b0, 8'd255, 1'b0, 16'd0);
        for (int n = 1; n < 65792; n++) begin
            tick(1'b1, 1'b0, 8'd255);
        end
        tick(1'b1, 1'b0, 8'd255);
        chk("wraps_65535", 4'd0, 1'b1, 8'd255, 1'b0, 16'd65535);
        tick(1'b1, 1'b0, 8'd255);
        chk("no_carry_from_0", 4'd15, 1'b0, 8'd255, 1'b0, 16'd65535);
        tick(1'b1, 1'b0, 8'd255);
        chk("count_rollover", 4'd15, 1'b1, 8'd255, 1'b0, 16'd0);

        tick(1'b0, 1'b0, 8'd7);
        chk("pending_before_reset", 4'd15, 1'b0, 8'd255, 1'b1, 16'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 4'd0, 1'b0, 8'd16, 1'b0, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nco_phase_accumulator.md
# nco_phase_accumulator

Phase-continuous numerically controlled oscillator core for the lock-in channels. It sits directly downstream of the Avalon-MM frequency-control PIO and consumes its 20-bit `out_port` frequency word. It produces in-phase and quadrature phase words, square-wave references, and a per-period wrap pulse for the demodulators. New frequency words are applied only at a phase wrap, so the reference never jumps mid-period.

## Interface
- `ACC_W`, 32: phase accumulator width.
- `FREQ_W`, 20: frequency word width.
- `FREQ_SHIFT`, 12: left shift applied to the frequency word to form the increment. Constraint: FREQ_W+FREQ_SHIFT ≤ ACC_W.
- `OUT_W`, 12: phase output width (top bits of the accumulator). Constraint: OUT_W ≥ 3.
- `RESET_FREQ`, 1310: active frequency word after reset. Matches the PIO reset value.

Ports:
- `clk` input 1: single system clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `freq_word` input FREQ_W: requested frequency, driven from the PIO `out_port`.
- `enable` input 1: accumulator advances when high.
- `sync_clear` input 1: synchronous phase restart.
- `phase_i` output OUT_W: in-phase phase word.
- `phase_q` output OUT_W: quadrature phase word.
- `ref_i` output 1: in-phase square reference.
- `ref_q` output 1: quadrature square reference.
- `wrap_pulse` output 1: one-cycle pulse on accumulator overflow.
- `freq_active` output FREQ_W: frequency word currently in use.
- `freq_pending` output 1: high while `freq_word` differs from `freq_active`.
- `cycle_count` output 16: count of completed periods.

## Operation
- Increment:
  - inc = freq_active zero-extended to ACC_W, then shifted left by FREQ_SHIFT.
  - acc_next = acc + inc, computed modulo 2^ACC_W. The carry out is the wrap.
- Phase outputs:
  - `phase_i` = acc[ACC_W-1 -: OUT_W], combinational from the acc register.
  - `phase_q` = (phase_i + 2^(OUT_W-2)) mod 2^OUT_W, which is a +90° offset.
- Square references: `ref_i` = MSB of phase_i. `ref_q` = MSB of phase_q.
- Per-edge priority, highest first:
  1. `sync_clear`=1:
     - acc←0, freq_active←freq_word, freq_pending←0, cycle_count←0, wrap_pulse←0.
  2. `enable`=1:
     - acc←acc_next, wrap_pulse←carry.
     - On carry: cycle_count←cycle_count+1, wrapping 65535→0.
     - On carry: freq_active←freq_word.
  3. `enable`=0:
     - acc holds, wrap_pulse←0.
- Zero-frequency escape: if freq_active==0 and freq_word≠0, then freq_active←freq_word on the next edge, regardless of `enable`. Otherwise a zero frequency never wraps and the new word could never be loaded.
- `freq_pending` is registered:
  - freq_pending←(freq_word≠freq_active), evaluated against the value freq_active takes after this edge.
  - If the requested word returns to the active value before a wrap, pending clears with no load.
- freq_word changing on the wrap edge: the value sampled at that edge is the one loaded.

## Timing
- Reset values:
  - acc=0, so phase_i=0 and phase_q=2^(OUT_W-2).
  - ref_i=0, ref_q=0, wrap_pulse=0, cycle_count=0.
  - freq_active=RESET_FREQ, freq_pending=0.
- Phase outputs and refs update in the cycle after the edge that updates acc; there is no extra pipeline stage.
- `wrap_pulse` is high during the cycle in which acc holds the post-overflow value. Its width is exactly one cycle per wrap.
- A new frequency takes effect on the increment that follows the wrap edge. The wrap residue itself used the old increment.
- `freq_pending` rises 1 cycle after `freq_word` changes. It falls in the same cycle `wrap_pulse` rises.
- `sync_clear` and a carry on the same edge: the clear wins, with no wrap_pulse and cycle_count=0.
- Asynchronous reset mid-period: all state returns immediately to the reset values. The pending request is discarded.

## Test plan
Bench parameters: ACC_W=8, FREQ_W=8, FREQ_SHIFT=0, OUT_W=4, RESET_FREQ=16.

1. Reset release, enable=1, freq_word=16 -> phase_i counts 1,2,…,15,0. wrap_pulse is high only on the 16th cycle. cycle_count=1 after that cycle. phase_q=phase_i+4 mod 16. ref_i toggles every 8 cycles; ref_q leads ref_i by 4 cycles.
2. Set freq_word=32 at cycle 5 -> freq_pending=1 at cycle 6. Increment stays 16 until the wrap at cycle 16, when freq_pending=0 and freq_active=32. The next wraps occur every 8 cycles.
3. freq_word=0 applied at a wrap -> acc freezes and no further wrap_pulse occurs. Then freq_word=48 -> freq_active=48 one edge later, without a wrap. Next acc values are 48, 96, ….
4. Pulse sync_clear on the same edge a carry would occur, with freq_word=64 -> acc=0, wrap_pulse=0, cycle_count=0, freq_active=64, freq_pending=0.
5. enable=0 for 10 cycles mid-period -> phase_i holds and wrap_pulse stays 0. Re-enable -> the sequence resumes from the held value.
6. Run 65536 wraps at freq_word=255 -> cycle_count wraps 65535→0. Assert reset_n low mid-period -> all outputs return to the reset values asynchronously.
